mas_alu_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one MAS ALU between NUM_REQ requesters.
- Accepts one operation at a time and launches it with a single-cycle request pulse.
- Waits for ALU completion, with a timeout guard, then returns the result to the winning requester over a valid/ready response channel.
- Sits between requester ports and the ALU control FSM's req/ready interface.

---
 rtl/mas_alu_arb.sv | 191 +++++++++++++++++++
 tb/tb_mas_alu_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mas_alu_arb.sv
// Round-robin arbiter sharing one MAS ALU between NUM_REQ requesters.
// Launches one op at a time, waits with a timeout guard, returns the result.
module mas_alu_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      alu_req,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic                      alu_idle,
  input  logic                      alu_done,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] PTR_RST  = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       win_q, win_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  rvld_q, rvld_d;

  logic                found;
  logic [IW-1:0]       win_c;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                grant;
  logic                hs;

  // Search starts just past the last winner, wrapping around.
  always_comb begin : pick
    int j;
    found = 1'b0;
    win_c = '0;
    j     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_valid[IW'(j)]) begin
        found = 1'b1;
        win_c = IW'(j);
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_c == IW'(i)) begin
        sel_op = req_op[i*OP_W +: OP_W];
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant     = (state_q == S_IDLE) && found && alu_idle;
  assign req_ready = grant ? (NUM_REQ'(1) << win_c) : '0;
  assign hs        = |(rsp_ready & rvld_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    rvld_d  = rvld_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (grant) begin
          win_d   = win_c;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = S_ISSUE;
        end
      end
      (state_q == S_ISSUE): begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      (state_q == S_WAIT): begin
        // Completion beats expiry when both land together.
        if (alu_done) begin
          data_d  = alu_result;
          err_d   = 1'b0;
          rvld_d  = NUM_REQ'(1) << win_q;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          rvld_d  = NUM_REQ'(1) << win_q;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      (state_q == S_RESP): begin
        if (hs) begin
          rvld_d  = '0;
          ptr_d   = win_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      win_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rvld_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rvld_q  <= rvld_d;
    end
  end

  assign alu_req   = (state_q == S_ISSUE);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rvld_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);

  a_rdy_oh: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_vld_oh: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rsp_valid));
  a_req_issue: assert property (@(posedge clk) disable iff (!rst_n)
    alu_req |-> (state_q == S_ISSUE));
  a_state_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(state_q));
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    ((|rsp_valid) && !(|(rsp_ready & rsp_valid))) |=> $stable(rsp_data));

endmodule

// File: tb/tb_mas_alu_arb.sv
// Directed table-driven bench for mas_alu_arb.
// Hand-written sequences cover ALU-busy stall and reset mid-WAIT.
module tb_mas_alu_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int TO = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_op;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            alu_req;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic            alu_idle;
  logic            alu_done;
  logic [DW-1:0]   alu_result;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;

  int checks = 0;
  int errors = 0;

  mas_alu_arb #(
    .NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_req(alu_req), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_idle(alu_idle), .alu_done(alu_done),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    int          idle_wait;
    int          w;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    int          bp;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t tbl[13];

  task automatic run_vec(input vec_t v, input int id);
    logic [N-1:0] oh;
    logic [DW-1:0] d0;
    int  k;
    int  pulses;
    int  wc;
    int  expk;
    bit  got;
    oh   = N'(1) << v.w;
    expk = (v.delay == 0) ? TO - 1 : v.delay;
    for (int i = 0; i < N; i++) begin
      if (i == v.w) begin
        req_op[i*OW +: OW] = v.op;
        req_a[i*DW +: DW]  = v.a;
        req_b[i*DW +: DW]  = v.b;
      end else begin
        req_op[i*OW +: OW] = OW'(i);
        req_a[i*DW +: DW]  = 32'hBAD0_0000 | DW'(i);
        req_b[i*DW +: DW]  = 32'h0BAD_0000;
      end
    end
    req_valid = v.valid;
    rsp_ready = '0;
    alu_done  = 1'b0;
    if (v.idle_wait > 0) begin
      alu_idle = 1'b0;
      for (int c = 0; c < v.idle_wait; c++) begin
        #1;
        chk($sformatf("v%0d_stall", id), {req_ready, alu_req}, '0);
        @(negedge clk);
      end
      alu_idle = 1'b1;
    end
    got = 0;
    wc  = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (|req_ready) begin
        got = 1;
        break;
      end
      wc++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_grant_seen", id), got, 1);
    if (!got) begin
      req_valid = '0;
      return;
    end
    chk($sformatf("v%0d_grant", id), req_ready, oh);
    chk($sformatf("v%0d_grant_wait", id), wc, 0);
    @(negedge clk);
    chk($sformatf("v%0d_alu_req", id), alu_req, 1);
    chk($sformatf("v%0d_alu_op", id), alu_op, v.op);
    chk($sformatf("v%0d_alu_ab", id), {alu_a, alu_b}, {v.a, v.b});
    chk($sformatf("v%0d_issue_busy", id), {busy, req_ready}, {1'b1, 4'b0});
    k      = 0;
    pulses = 0;
    got    = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (|rsp_valid) begin
        got = 1;
        break;
      end
      if (alu_req) pulses++;
      k++;
      alu_done   = (k == v.delay);
      alu_result = alu_done ? alu_a + alu_b : 32'hDEAD_BEEF;
    end
    alu_done = 1'b0;
    chk($sformatf("v%0d_rsp_seen", id), got, 1);
    chk($sformatf("v%0d_wait_cycles", id), k, expk);
    chk($sformatf("v%0d_req_pulse", id), pulses, 0);
    chk($sformatf("v%0d_rsp_valid", id), rsp_valid, oh);
    chk($sformatf("v%0d_rsp_data", id), rsp_data, v.data);
    chk($sformatf("v%0d_rsp_err", id), rsp_err, v.err);
    chk($sformatf("v%0d_op_hold", id), alu_op, v.op);
    d0 = rsp_data;
    if (v.bp > 0) begin
      rsp_ready = ~oh;
      for (int c = 0; c < v.bp; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d_bp_valid", id), rsp_valid, oh);
        chk($sformatf("v%0d_bp_data", id), rsp_data, d0);
        chk($sformatf("v%0d_bp_nogrant", id), req_ready, '0);
      end
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    chk($sformatf("v%0d_idle", id), {busy, rsp_valid}, '0);
  endtask

  task automatic reset_mid_wait();
    bit got;
    req_valid = 4'b0100;
    alu_idle  = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (|req_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_grant_seen", got, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_wait", busy, 1);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_async_ctl", {alu_req, rsp_valid, rsp_err, busy}, '0);
    chk("rst_async_data", rsp_data, '0);
    chk("rst_async_ab", {alu_a, alu_b}, '0);
    chk("rst_async_op", alu_op, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    alu_done   = 1'b1;
    alu_result = 32'h0000_CAFE;
    @(negedge clk);
    alu_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_no_stale", {busy, rsp_valid}, '0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    alu_idle   = 1'b1;
    alu_done   = 1'b0;
    alu_result = '0;
    rsp_ready  = '0;

    tbl[0]  = '{4'hF, 0, 0, 4'd1, 32'd1, 32'd2, 1, 0, 32'd3, 1'b0};
    tbl[1]  = '{4'hF, 0, 1, 4'd2, 32'd10, 32'd20, 1, 0, 32'd30, 1'b0};
    tbl[2]  = '{4'hF, 0, 2, 4'd3, 32'd100, 32'd1, 1, 0, 32'd101, 1'b0};
    tbl[3]  = '{4'hF, 0, 3, 4'd4, 32'h1000, 32'h0234, 1, 0,
                32'h1234, 1'b0};
    tbl[4]  = '{4'hF, 0, 0, 4'd5, 32'd7, 32'd8, 2, 0, 32'd15, 1'b0};
    tbl[5]  = '{4'b0100, 0, 2, 4'd3, 32'd5, 32'd7, 3, 0, 32'd12, 1'b0};
    tbl[6]  = '{4'b0001, 0, 0, 4'd6, 32'h7FFF_FFFF, 32'd1, 1, 5,
                32'h8000_0000, 1'b0};
    tbl[7]  = '{4'b1000, 0, 3, 4'd7, 32'd9, 32'd9, 0, 0, 32'd0, 1'b1};
    tbl[8]  = '{4'b0010, 10, 1, 4'd8, 32'd3, 32'd4, 2, 0, 32'd7, 1'b0};
    tbl[9]  = '{4'b0100, 0, 2, 4'd9, 32'd1, 32'd1, 15, 0, 32'd2, 1'b0};
    tbl[10] = '{4'b1011, 0, 3, 4'd10, 32'hFFFF_FFFF, 32'd2, 1, 0,
                32'd1, 1'b0};
    tbl[11] = '{4'b0011, 0, 0, 4'd11, 32'd0, 32'd0, 4, 0, 32'd0, 1'b0};
    tbl[12] = '{4'hF, 0, 0, 4'd12, 32'd40, 32'd2, 1, 0, 32'd42, 1'b0};

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_ctl", {alu_req, rsp_valid, rsp_err, busy, req_ready}, '0);
    chk("reset_data", {rsp_data, alu_op}, '0);
    chk("reset_ab", {alu_a, alu_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);
    reset_mid_wait();
    run_vec(tbl[12], 12);
    req_valid = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
